// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared types, ASCII constants and command lookup for the
//               base-side UART drive-command receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_BACK  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4
    } drive_cmd_t;

    localparam logic [7:0] c_ascii_s = 8'h53;
    localparam logic [7:0] c_ascii_f = 8'h46;
    localparam logic [7:0] c_ascii_b = 8'h42;
    localparam logic [7:0] c_ascii_l = 8'h4C;
    localparam logic [7:0] c_ascii_r = 8'h52;
    localparam logic [7:0] c_ascii_0 = 8'h30;

    typedef struct packed {
        logic       valid;
        drive_cmd_t cmd;
    } cmd_lookup_t;

    typedef enum logic [2:0] {
        BYTE_IDLE    = 3'd0,
        BYTE_START   = 3'd1,
        BYTE_DATA    = 3'd2,
        BYTE_STOP    = 3'd3,
        BYTE_RECOVER = 3'd4
    } byte_state_t;

    typedef enum logic [0:0] {
        DEC_WAIT_CMD  = 1'b0,
        DEC_WAIT_MULT = 1'b1
    } dec_state_t;

    function automatic cmd_lookup_t ascii_to_cmd(input logic [7:0] b);
        cmd_lookup_t res;
        res.valid = 1'b1;
        res.cmd   = CMD_STOP;
        case (b)
            c_ascii_s: res.cmd = CMD_STOP;
            c_ascii_f: res.cmd = CMD_FWD;
            c_ascii_b: res.cmd = CMD_BACK;
            c_ascii_l: res.cmd = CMD_LEFT;
            c_ascii_r: res.cmd = CMD_RIGHT;
            default:   res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 2-FF synchroniser plus 8N1 byte deserialiser with glitch
//               rejection, framing-error detection and break recovery.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int                 c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    byte_state_t        r_state;
    byte_state_t        w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_rx;
    logic               w_fall;
    logic               w_tick_half;
    logic               w_tick_full;

    // Flops preset high so reset looks like an idle line, not a start bit.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rx        = r_sync2;
    assign w_fall      = r_prev & ~r_sync2;
    assign w_tick_half = (r_cnt == c_half_m1);
    assign w_tick_full = (r_cnt == c_full_m1);
    assign busy        = (r_state != BYTE_IDLE);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state <= BYTE_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BYTE_IDLE:    if (w_fall) w_next = BYTE_START;
            BYTE_START:   if (w_tick_half) w_next = w_rx ? BYTE_IDLE : BYTE_DATA;
            BYTE_DATA:    if (w_tick_full && (r_bit_idx == 3'd7)) w_next = BYTE_STOP;
            BYTE_STOP:    if (w_tick_full) w_next = w_rx ? BYTE_IDLE : BYTE_RECOVER;
            BYTE_RECOVER: if (w_rx) w_next = BYTE_IDLE;
            default:      w_next = BYTE_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            data        <= 8'h00;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_error <= 1'b0;
            case (r_state)
                BYTE_START: begin
                    r_cnt <= w_tick_half ? '0 : r_cnt + c_one;
                end
                BYTE_DATA: begin
                    if (w_tick_full) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                BYTE_STOP: begin
                    if (w_tick_full) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_command_rx.sv
// ============================================================================
// Module      : uart_command_rx
// Description : UART drive-command receiver; decodes two-byte ASCII frames
//               (letter, digit) into command/multiplier. Optional macro
//               UART_CMD_RX_TIMEOUT_EN adds an inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_command_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       uart_in,
    output logic [2:0] command,
    output logic [2:0] multiplier,
    output logic       cmd_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_error,
    output logic       decode_error,
    output logic       busy
);

    dec_state_t  r_dec_state;
    dec_state_t  w_dec_next;
    drive_cmd_t  r_pending;
    cmd_lookup_t w_lookup;
    logic        w_is_digit;
    logic        w_load_pending;
    logic        w_fire;
    logic        w_dec_err;
    logic        w_timeout;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk_50      (clk_50),
        .reset       (reset),
        .rx          (uart_in),
        .data        (rx_byte),
        .valid       (rx_byte_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    assign w_lookup   = ascii_to_cmd(rx_byte);
    assign w_is_digit = (rx_byte[7:3] == c_ascii_0[7:3]);

`ifdef UART_CMD_RX_TIMEOUT_EN
    localparam int                c_to_w    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CLKS - 1);
    localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

    logic [c_to_w-1:0] r_to_cnt;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_dec_state != DEC_WAIT_MULT) || rx_byte_valid) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_to_last) begin
            r_to_cnt <= r_to_cnt + c_to_one;
        end
    end

    // A byte arriving on the deadline cycle wins over the timeout.
    assign w_timeout = (r_dec_state == DEC_WAIT_MULT) && (r_to_cnt == c_to_last)
                       && !rx_byte_valid;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_dec_state <= DEC_WAIT_CMD;
        end else begin
            r_dec_state <= w_dec_next;
        end
    end

    always_comb begin
        w_dec_next     = r_dec_state;
        w_load_pending = 1'b0;
        w_fire         = 1'b0;
        w_dec_err      = 1'b0;
        if (rx_byte_valid) begin
            case (r_dec_state)
                DEC_WAIT_CMD: begin
                    if (w_lookup.valid) begin
                        w_load_pending = 1'b1;
                        w_dec_next     = DEC_WAIT_MULT;
                    end else begin
                        w_dec_err = 1'b1;
                    end
                end
                DEC_WAIT_MULT: begin
                    if (w_is_digit) begin
                        w_fire     = 1'b1;
                        w_dec_next = DEC_WAIT_CMD;
                    end else if (w_lookup.valid) begin
                        w_dec_err      = 1'b1;
                        w_load_pending = 1'b1;
                    end else begin
                        w_dec_err  = 1'b1;
                        w_dec_next = DEC_WAIT_CMD;
                    end
                end
                default: w_dec_next = DEC_WAIT_CMD;
            endcase
        end else if (w_timeout) begin
            w_dec_err  = 1'b1;
            w_dec_next = DEC_WAIT_CMD;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_pending    <= CMD_STOP;
            command      <= 3'd0;
            multiplier   <= 3'd0;
            cmd_valid    <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            cmd_valid    <= w_fire;
            decode_error <= w_dec_err;
            if (w_load_pending) begin
                r_pending <= w_lookup.cmd;
            end
            if (w_fire) begin
                command    <= r_pending;
                multiplier <= rx_byte[2:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_command_rx.sv
// ============================================================================
// Module      : tb_uart_command_rx
// Description : Scoreboard bench for uart_command_rx with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_command_rx;

    localparam int CPB = 250;
    localparam int TO  = 1000;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b1;
    logic       uart_in = 1'b1;
    logic [2:0] command;
    logic [2:0] multiplier;
    logic       cmd_valid;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_error;
    logic       decode_error;
    logic       busy;

    uart_command_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk_50        (clk_50),
        .reset         (reset),
        .uart_in       (uart_in),
        .command       (command),
        .multiplier    (multiplier),
        .cmd_valid     (cmd_valid),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_error   (frame_error),
        .decode_error  (decode_error),
        .busy          (busy)
    );

    always #10 clk_50 = ~clk_50;

    int unsigned cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_byte[$];
    logic [5:0] q_cmd[$];
    int         q_ferr[$];
    int         q_derr[$];
    int unsigned last_rxv_cyc = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Monitor: pops expected responses whenever a strobe is presented.
    always @(negedge clk_50) begin
        if (!reset) begin
            if (rx_byte_valid) begin
                last_rxv_cyc = cyc;
                check("rx_byte_valid expected", int'(q_byte.size() > 0), 1);
                if (q_byte.size() > 0) check("rx_byte", rx_byte, q_byte.pop_front());
            end
            if (cmd_valid) begin
                check("cmd_valid expected", int'(q_cmd.size() > 0), 1);
                if (q_cmd.size() > 0) begin
                    logic [5:0] e;
                    e = q_cmd.pop_front();
                    check("command", command, e[5:3]);
                    check("multiplier", multiplier, e[2:0]);
                    check("cmd_valid latency", int'(cyc - last_rxv_cyc), 1);
                end
            end
            if (frame_error) begin
                check("frame_error expected", int'(q_ferr.size() > 0), 1);
                if (q_ferr.size() > 0) void'(q_ferr.pop_front());
            end
            if (decode_error) begin
                check("decode_error expected", int'(q_derr.size() > 0), 1);
                if (q_derr.size() > 0) void'(q_derr.pop_front());
            end
            if ((frame_error | decode_error) & (rx_byte_valid | cmd_valid))
                check("error/valid exclusive", 1, 0);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int gap_bits);
        uart_in = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            wait_clks(CPB);
        end
        uart_in = stop_val;
        wait_clks(CPB);
        uart_in = 1'b1;
        wait_clks(gap_bits * CPB);
    endtask

    task automatic send_good(input logic [7:0] b, input int gap_bits);
        q_byte.push_back(b);
        send_byte(b, 1'b1, gap_bits);
    endtask

    initial begin
        wait_clks(3);
        check("reset command", command, 0);
        check("reset multiplier", multiplier, 0);
        check("reset cmd_valid", cmd_valid, 0);
        check("reset rx_byte", rx_byte, 0);
        check("reset rx_byte_valid", rx_byte_valid, 0);
        check("reset frame_error", frame_error, 0);
        check("reset decode_error", decode_error, 0);
        check("reset busy", busy, 0);
        reset = 1'b0;
        wait_clks(5);

        // 'F','3' with one idle bit between bytes
        q_cmd.push_back({3'd1, 3'd3});
        send_good(8'h46, 1);
        send_good(8'h33, 1);

        // 'R','7','S','0' back-to-back
        q_cmd.push_back({3'd4, 3'd7});
        q_cmd.push_back({3'd0, 3'd0});
        send_good(8'h52, 0);
        send_good(8'h37, 0);
        send_good(8'h53, 0);
        send_good(8'h30, 1);

        // 100-cycle low glitch on an idle line
        uart_in = 1'b0;
        wait_clks(50);
        check("busy during glitch", busy, 1);
        wait_clks(50);
        uart_in = 1'b1;
        wait_clks(217);
        check("busy after glitch", busy, 0);

        // 0x46 with a low stop bit, then 'L','2'
        q_ferr.push_back(1);
        send_byte(8'h46, 1'b0, 2);
        q_cmd.push_back({3'd3, 3'd2});
        send_good(8'h4C, 1);
        send_good(8'h32, 1);

        // 'X' rejected, 'B' replaced by 'L' on resync, then '5'
        q_derr.push_back(1);
        send_good(8'h58, 1);
        send_good(8'h42, 1);
        q_derr.push_back(2);
        send_good(8'h4C, 1);
        q_cmd.push_back({3'd3, 3'd5});
        send_good(8'h35, 1);

        // 'F', long gap, '4'
`ifdef UART_CMD_RX_TIMEOUT_EN
        q_derr.push_back(3);
        q_derr.push_back(4);
`else
        q_cmd.push_back({3'd1, 3'd4});
`endif
        send_good(8'h46, 0);
        wait_clks(2000);
        send_good(8'h34, 1);

        // Reset mid-frame and mid-byte: pending 'B' must be forgotten
        send_good(8'h42, 1);
        uart_in = 1'b0;
        wait_clks(1000);
        reset = 1'b1;
        wait_clks(3);
        check("mid-byte reset busy", busy, 0);
        check("mid-byte reset cmd_valid", cmd_valid, 0);
        uart_in = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2 * CPB);
        check("busy after reset release", busy, 0);
        q_derr.push_back(5);
        send_good(8'h31, 2);

        check("pending rx_byte queue", q_byte.size(), 0);
        check("pending cmd queue", q_cmd.size(), 0);
        check("pending frame_error queue", q_ferr.size(), 0);
        check("pending decode_error queue", q_derr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
